// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: holds one instruction slot (valid, instr, PC,
// branch-delay flag, exception code) plus a multi-lane opaque payload.
// Each rising edge applies exactly one action: reset > flush > stall > load.
// Every output is driven straight from a register, so nothing on the input
// side reaches an output without passing through a clock edge.
module pipe_stage_reg #(
    parameter int          DATA_W = 32,
    parameter int          LANES  = 4,
    parameter logic [31:0] PC_RST = 32'h0000_3000,
    parameter int          CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [31:0]               in_instr,
    input  logic [31:0]               in_pc,
    input  logic                      in_bd,
    input  logic [4:0]                in_exc,
    input  logic [LANES*DATA_W-1:0]   in_data,
    output logic                      out_valid,
    output logic [31:0]               out_instr,
    output logic [31:0]               out_pc,
    output logic                      out_bd,
    output logic [4:0]                out_exc,
    output logic [LANES*DATA_W-1:0]   out_data,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic                      held
);

    // Stage registers. Power-up values equal the reset values so the
    // outputs are already well defined before the first clock edge.
    logic                    vld_p1       = 1'b0;
    logic [31:0]             instr_p1     = '0;
    logic [31:0]             pc_p1        = PC_RST;
    logic                    bd_p1        = 1'b0;
    logic [4:0]              exc_p1       = '0;
    logic [LANES*DATA_W-1:0] data_p1      = '0;
    logic [CNT_W-1:0]        stall_cnt_p1 = '0;
    logic                    held_p1      = 1'b0;

    // Saturating increment: the hold counter sticks at all-ones rather than
    // wrapping back to zero on very long stalls.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (&cnt) begin
            return cnt;
        end
        return cnt + CNT_W'(1);
    endfunction

    // Stage update: one action per edge, reset first, then flush, stall, load.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1       <= 1'b0;
            instr_p1     <= '0;
            pc_p1        <= PC_RST;
            bd_p1        <= 1'b0;
            exc_p1       <= '0;
            data_p1      <= '0;
            stall_cnt_p1 <= '0;
            held_p1      <= 1'b0;
        end else if (flush) begin
            // Bubble, but keep PC/BD so a later exception can still report
            // where the squashed instruction came from.
            vld_p1       <= 1'b0;
            instr_p1     <= '0;
            pc_p1        <= in_pc;
            bd_p1        <= in_bd;
            exc_p1       <= '0;
            data_p1      <= '0;
            stall_cnt_p1 <= '0;
            held_p1      <= 1'b0;
        end else if (stall) begin
            // Contents stay put; only the hold bookkeeping moves, and only
            // a real instruction counts as being held.
            stall_cnt_p1 <= vld_p1 ? sat_inc(stall_cnt_p1) : '0;
            held_p1      <= vld_p1;
        end else begin
            // Empty slots carry no instruction/exception/payload bits, but
            // PC/BD always follow the incoming slot.
            vld_p1       <= in_valid;
            instr_p1     <= in_valid ? in_instr : '0;
            pc_p1        <= in_pc;
            bd_p1        <= in_bd;
            exc_p1       <= in_valid ? in_exc : '0;
            data_p1      <= in_valid ? in_data : '0;
            stall_cnt_p1 <= '0;
            held_p1      <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_instr = instr_p1;
    assign out_pc    = pc_p1;
    assign out_bd    = bd_p1;
    assign out_exc   = exc_p1;
    assign out_data  = data_p1;
    assign stall_cnt = stall_cnt_p1;
    assign held      = held_p1;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three builds (LANES=4/CNT_W=16, LANES=1/CNT_W=2,
// LANES=8/CNT_W=16) share control inputs; a directed vector table, counter
// saturation and lane placement sequences, then random traffic checked
// against a per-instance behavioural model.
module tb_pipe_stage_reg;

    logic         clk = 1'b0;
    logic         reset = 1'b0, stall = 1'b0, flush = 1'b0, in_valid = 1'b0;
    logic [31:0]  in_instr = '0, in_pc = '0;
    logic         in_bd = 1'b0;
    logic [4:0]   in_exc = '0;
    logic [255:0] in_data8 = '0;

    logic valid_a, bd_a, held_a, valid_b, bd_b, held_b, valid_c, bd_c, held_c;
    logic [31:0]  instr_a, pc_a, instr_b, pc_b, instr_c, pc_c;
    logic [4:0]   exc_a, exc_b, exc_c;
    logic [127:0] data_a;
    logic [31:0]  data_b;
    logic [255:0] data_c;
    logic [15:0]  cnt_a, cnt_c;
    logic [1:0]   cnt_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .LANES(4), .PC_RST(32'h0000_3000), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_instr(in_instr), .in_pc(in_pc), .in_bd(in_bd), .in_exc(in_exc),
        .in_data(in_data8[127:0]), .out_valid(valid_a), .out_instr(instr_a),
        .out_pc(pc_a), .out_bd(bd_a), .out_exc(exc_a), .out_data(data_a),
        .stall_cnt(cnt_a), .held(held_a));

    pipe_stage_reg #(.DATA_W(32), .LANES(1), .PC_RST(32'h0000_3000), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_instr(in_instr), .in_pc(in_pc), .in_bd(in_bd), .in_exc(in_exc),
        .in_data(in_data8[31:0]), .out_valid(valid_b), .out_instr(instr_b),
        .out_pc(pc_b), .out_bd(bd_b), .out_exc(exc_b), .out_data(data_b),
        .stall_cnt(cnt_b), .held(held_b));

    pipe_stage_reg #(.DATA_W(32), .LANES(8), .PC_RST(32'h0000_3000), .CNT_W(16)) dut_c (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_instr(in_instr), .in_pc(in_pc), .in_bd(in_bd), .in_exc(in_exc),
        .in_data(in_data8), .out_valid(valid_c), .out_instr(instr_c),
        .out_pc(pc_c), .out_bd(bd_c), .out_exc(exc_c), .out_data(data_c),
        .stall_cnt(cnt_c), .held(held_c));

    // Behavioural model: what each build's outputs should be.
    typedef struct {
        logic         valid;
        logic [31:0]  instr;
        logic [31:0]  pc;
        logic         bd;
        logic [4:0]   exc;
        logic [255:0] data;
        int           cnt;
        logic         held;
    } mstate_t;

    mstate_t m[3];
    int lanes[3] = '{4, 1, 8};
    int cmax[3]  = '{65535, 3, 65535};

    function automatic mstate_t rst_state();
        mstate_t s;
        s.valid = 1'b0; s.instr = '0; s.pc = 32'h0000_3000; s.bd = 1'b0;
        s.exc = '0; s.data = '0; s.cnt = 0; s.held = 1'b0;
        return s;
    endfunction

    task automatic model_step(int i);
        mstate_t s = m[i];
        logic [255:0] mask;
        mask = (lanes[i] == 8) ? {256{1'b1}} : ((256'd1 << (lanes[i] * 32)) - 256'd1);
        if (reset) begin
            s = rst_state();
        end else if (flush) begin
            s.valid = 1'b0; s.instr = '0; s.exc = '0; s.data = '0;
            s.pc = in_pc; s.bd = in_bd; s.cnt = 0; s.held = 1'b0;
        end else if (stall) begin
            if (s.valid) begin
                s.cnt = (s.cnt < cmax[i]) ? s.cnt + 1 : cmax[i];
                s.held = 1'b1;
            end else begin
                s.cnt = 0;
                s.held = 1'b0;
            end
        end else begin
            s.valid = in_valid; s.pc = in_pc; s.bd = in_bd;
            s.instr = in_valid ? in_instr : 32'h0;
            s.exc   = in_valid ? in_exc : 5'h0;
            s.data  = in_valid ? (in_data8 & mask) : 256'h0;
            s.cnt = 0; s.held = 1'b0;
        end
        m[i] = s;
    endtask

    task automatic cmp(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_dut(string tag, int i, logic v, logic [31:0] ins, logic [31:0] pc,
                             logic bd, logic [4:0] exc, logic [255:0] data, int cnt, logic hd);
        cmp({tag, ".valid"}, 256'(v), 256'(m[i].valid));
        cmp({tag, ".instr"}, 256'(ins), 256'(m[i].instr));
        cmp({tag, ".pc"}, 256'(pc), 256'(m[i].pc));
        cmp({tag, ".bd"}, 256'(bd), 256'(m[i].bd));
        cmp({tag, ".exc"}, 256'(exc), 256'(m[i].exc));
        cmp({tag, ".data"}, data, m[i].data);
        cmp({tag, ".stall_cnt"}, 256'(cnt), 256'(m[i].cnt));
        cmp({tag, ".held"}, 256'(hd), 256'(m[i].held));
    endtask

    task automatic check_all();
        check_dut("A", 0, valid_a, instr_a, pc_a, bd_a, exc_a, 256'(data_a), int'(cnt_a), held_a);
        check_dut("B", 1, valid_b, instr_b, pc_b, bd_b, exc_b, 256'(data_b), int'(cnt_b), held_b);
        check_dut("C", 2, valid_c, instr_c, pc_c, bd_c, exc_c, data_c, int'(cnt_c), held_c);
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i);
        #1;
        check_all();
    endtask

    function automatic logic [31:0] lane_pat(int k);
        logic [7:0] b;
        b = 8'(k + 1);
        return {b, ~b, 8'(k * 17), 8'hA5};
    endfunction

    // Directed vectors with hand-written expectations for build A.
    typedef struct {
        logic        rst, fl, st, v;
        logic [31:0] instr, pc;
        logic        bd;
        logic [4:0]  exc;
        logic [31:0] lane0;
        logic        e_v;
        logic [31:0] e_instr, e_pc;
        logic        e_bd;
        logic [4:0]  e_exc;
        logic [31:0] e_lane0;
        int          e_cnt;
        logic        e_held;
    } vec_t;

    vec_t vt[13];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 3; i++) m[i] = rst_state();

        //        rst fl st v  instr          pc             bd exc   lane0           e_v e_instr        e_pc           e_bd e_exc e_lane0      cnt held
        vt[0]  = '{1, 0, 0, 0, 32'h0,         32'h0,         0, 5'd0, 32'h0,          0, 32'h0,         32'h0000_3000, 0, 5'd0, 32'h0,         0, 0};
        vt[1]  = '{0, 0, 0, 1, 32'h0123_4020, 32'h0000_3004, 0, 5'd0, 32'hDEAD_BEEF,  1, 32'h0123_4020, 32'h0000_3004, 0, 5'd0, 32'hDEAD_BEEF, 0, 0};
        vt[2]  = '{0, 0, 1, 1, 32'h1111_1111, 32'h0000_3008, 1, 5'd1, 32'h0000_0001,  1, 32'h0123_4020, 32'h0000_3004, 0, 5'd0, 32'hDEAD_BEEF, 1, 1};
        vt[3]  = '{0, 0, 1, 1, 32'h2222_2222, 32'h0000_300C, 0, 5'd2, 32'h0000_0002,  1, 32'h0123_4020, 32'h0000_3004, 0, 5'd0, 32'hDEAD_BEEF, 2, 1};
        vt[4]  = '{0, 0, 1, 0, 32'h3333_3333, 32'h0000_3010, 1, 5'd3, 32'h0000_0003,  1, 32'h0123_4020, 32'h0000_3004, 0, 5'd0, 32'hDEAD_BEEF, 3, 1};
        vt[5]  = '{0, 0, 0, 1, 32'h4444_4444, 32'h0000_300C, 1, 5'd3, 32'h0000_55AA,  1, 32'h4444_4444, 32'h0000_300C, 1, 5'd3, 32'h0000_55AA, 0, 0};
        vt[6]  = '{0, 1, 1, 1, 32'h0000_0099, 32'h0000_3010, 1, 5'd4, 32'h0000_CAFE,  0, 32'h0,         32'h0000_3010, 1, 5'd0, 32'h0,         0, 0};
        vt[7]  = '{0, 0, 1, 1, 32'h0000_0088, 32'h0000_3020, 0, 5'd1, 32'h0000_0BAD,  0, 32'h0,         32'h0000_3010, 1, 5'd0, 32'h0,         0, 0};
        vt[8]  = '{0, 0, 0, 0, 32'h0000_0077, 32'h0000_3024, 0, 5'd7, 32'h0000_0ABC,  0, 32'h0,         32'h0000_3024, 0, 5'd0, 32'h0,         0, 0};
        vt[9]  = '{0, 0, 0, 1, 32'h0000_0005, 32'h0000_3028, 0, 5'd2, 32'h0000_1234,  1, 32'h0000_0005, 32'h0000_3028, 0, 5'd2, 32'h0000_1234, 0, 0};
        vt[10] = '{0, 0, 1, 1, 32'h0000_0006, 32'h0000_302C, 1, 5'd9, 32'h0000_5678,  1, 32'h0000_0005, 32'h0000_3028, 0, 5'd2, 32'h0000_1234, 1, 1};
        vt[11] = '{1, 1, 1, 1, 32'h0000_0007, 32'h0000_3030, 1, 5'd4, 32'h0000_9999,  0, 32'h0,         32'h0000_3000, 0, 5'd0, 32'h0,         0, 0};
        vt[12] = '{0, 0, 0, 1, 32'h0000_0ABC, 32'h0000_3040, 0, 5'd0, 32'h0000_0001,  1, 32'h0000_0ABC, 32'h0000_3040, 0, 5'd0, 32'h0000_0001, 0, 0};

        // Power-up values before any edge.
        #1;
        check_all();
        cmp("t0.pc_a", 256'(pc_a), 256'(32'h0000_3000));

        for (int r = 0; r < 13; r++) begin
            reset = vt[r].rst; flush = vt[r].fl; stall = vt[r].st; in_valid = vt[r].v;
            in_instr = vt[r].instr; in_pc = vt[r].pc; in_bd = vt[r].bd; in_exc = vt[r].exc;
            in_data8 = {224'h0, vt[r].lane0};
            cycle();
            cmp($sformatf("vec%0d.valid", r), 256'(valid_a), 256'(vt[r].e_v));
            cmp($sformatf("vec%0d.instr", r), 256'(instr_a), 256'(vt[r].e_instr));
            cmp($sformatf("vec%0d.pc", r), 256'(pc_a), 256'(vt[r].e_pc));
            cmp($sformatf("vec%0d.bd", r), 256'(bd_a), 256'(vt[r].e_bd));
            cmp($sformatf("vec%0d.exc", r), 256'(exc_a), 256'(vt[r].e_exc));
            cmp($sformatf("vec%0d.data", r), 256'(data_a), {224'h0, vt[r].e_lane0});
            cmp($sformatf("vec%0d.cnt", r), 256'(cnt_a), 256'(vt[r].e_cnt));
            cmp($sformatf("vec%0d.held", r), 256'(held_a), 256'(vt[r].e_held));
        end

        // Long stall on valid contents: 2-bit counter saturates at 3.
        stall = 1'b1; reset = 1'b0; flush = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_instr = $urandom; in_pc = $urandom;
            cycle();
            cmp($sformatf("sat%0d.cnt_b", k), 256'(cnt_b), 256'((k < 3) ? k + 1 : 3));
            cmp($sformatf("sat%0d.cnt_a", k), 256'(cnt_a), 256'(k + 1));
        end
        stall = 1'b0;

        // Distinct pattern per lane: each lane must land in its own slice.
        in_valid = 1'b1; in_instr = 32'hC0DE_0001; in_pc = 32'h0000_3100;
        in_bd = 1'b0; in_exc = '0;
        for (int k = 0; k < 8; k++) in_data8[k*32 +: 32] = lane_pat(k);
        cycle();
        for (int k = 0; k < 8; k++) begin
            logic [31:0] lc;
            lc = data_c[k*32 +: 32];
            cmp($sformatf("laneC%0d", k), 256'(lc), 256'(lane_pat(k)));
        end
        cmp("laneB0", 256'(data_b), 256'(lane_pat(0)));
        cmp("laneA", 256'(data_a),
            256'({lane_pat(3), lane_pat(2), lane_pat(1), lane_pat(0)}));

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            reset    = ($urandom_range(0, 31) == 0);
            flush    = ($urandom_range(0, 7) == 0);
            stall    = ($urandom_range(0, 2) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_instr = $urandom; in_pc = $urandom;
            in_bd    = 1'($urandom);
            in_exc   = 5'($urandom);
            for (int k = 0; k < 8; k++) in_data8[k*32 +: 32] = $urandom;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
